// File: rtl/mem_arbiter.sv
// Arbitrates the shared two-bank (big-endian hi/lo) RAM between the CPU data port and video fetch.
// Fixed 4-cycle access: IDLE grant -> ACCESS (RAM strobes) -> CAPTURE (load rdata) -> RESP (ack).
module mem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_wide,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_ack,
    output logic [14:0] ram_addr,
    output logic        ram_we_hi,
    output logic        ram_we_lo,
    output logic [7:0]  ram_wdata_hi,
    output logic [7:0]  ram_wdata_lo,
    input  logic [7:0]  ram_rdata_hi,
    input  logic [7:0]  ram_rdata_lo
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          own_vid;
    logic          own_wr;
    logic          own_wide;
    logic          own_lo;
    logic          grant_cpu;
    logic          grant_vid;

    // Word-wide video fetch never looks at the byte-select bit.
    logic unused_vid_addr0;
    assign unused_vid_addr0 = vid_addr[0];

    always_comb begin
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        if (cpu_req && vid_req) begin
            if (starve_cnt == SMAX)
                grant_cpu = 1'b1;
            else
                grant_vid = 1'b1;
        end else if (cpu_req) begin
            grant_cpu = 1'b1;
        end else if (vid_req) begin
            grant_vid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            own_vid      <= 1'b0;
            own_wr       <= 1'b0;
            own_wide     <= 1'b0;
            own_lo       <= 1'b0;
            cpu_rdata    <= 16'h0000;
            cpu_ack      <= 1'b0;
            vid_rdata    <= 16'h0000;
            vid_ack      <= 1'b0;
            ram_addr     <= 15'h0000;
            ram_we_hi    <= 1'b0;
            ram_we_lo    <= 1'b0;
            ram_wdata_hi <= 8'h00;
            ram_wdata_lo <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        own_vid      <= 1'b0;
                        own_wr       <= cpu_wr;
                        own_wide     <= cpu_wide;
                        own_lo       <= cpu_addr[0];
                        ram_addr     <= cpu_addr[15:1];
                        ram_we_hi    <= cpu_wr && (cpu_wide || !cpu_addr[0]);
                        ram_we_lo    <= cpu_wr && (cpu_wide || cpu_addr[0]);
                        // Byte writes replicate the low data byte onto both lanes.
                        ram_wdata_hi <= cpu_wide ? cpu_wdata[15:8] : cpu_wdata[7:0];
                        ram_wdata_lo <= cpu_wdata[7:0];
                        starve_cnt   <= '0;
                        state        <= ACCESS;
                    end else if (grant_vid) begin
                        own_vid  <= 1'b1;
                        own_wr   <= 1'b0;
                        own_wide <= 1'b1;
                        own_lo   <= 1'b0;
                        ram_addr <= vid_addr[15:1];
                        if (cpu_req && starve_cnt != SMAX)
                            starve_cnt <= starve_cnt + 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we_hi <= 1'b0;
                    ram_we_lo <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    if (own_vid) begin
                        vid_rdata <= {ram_rdata_hi, ram_rdata_lo};
                        vid_ack   <= 1'b1;
                    end else begin
                        if (!own_wr)
                            cpu_rdata <= own_wide ? {ram_rdata_hi, ram_rdata_lo}
                                                  : {8'h00, own_lo ? ram_rdata_lo : ram_rdata_hi};
                        cpu_ack <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    vid_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-bank synchronous RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr, cpu_wide;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        vid_req;
    logic [15:0] vid_addr, vid_rdata;
    logic        vid_ack;
    logic [14:0] ram_addr;
    logic        ram_we_hi, ram_we_lo;
    logic [7:0]  ram_wdata_hi, ram_wdata_lo;
    logic [7:0]  ram_rdata_hi, ram_rdata_lo;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_we_hi = 0;
    int cnt_we_lo = 0;

    logic [7:0] mem_hi [32768];
    logic [7:0] mem_lo [32768];

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wide(cpu_wide),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .ram_addr(ram_addr), .ram_we_hi(ram_we_hi), .ram_we_lo(ram_we_lo),
        .ram_wdata_hi(ram_wdata_hi), .ram_wdata_lo(ram_wdata_lo),
        .ram_rdata_hi(ram_rdata_hi), .ram_rdata_lo(ram_rdata_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_hi) begin
            mem_hi[ram_addr] <= ram_wdata_hi;
            cnt_we_hi <= cnt_we_hi + 1;
        end
        if (ram_we_lo) begin
            mem_lo[ram_addr] <= ram_wdata_lo;
            cnt_we_lo <= cnt_we_lo + 1;
        end
        ram_rdata_hi <= mem_hi[ram_addr];
        ram_rdata_lo <= mem_lo[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One CPU access from IDLE, checking strobes in T+1 and the ack/data in T+3.
    task automatic cpu_op(input string tag, input logic wr, input logic wide,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic exp_we_hi, input logic exp_we_lo,
                          input logic [15:0] exp_rdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_wide = wide; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        check({tag, " addr"}, 32'(ram_addr), 32'(addr[15:1]));
        check({tag, " we_hi"}, 32'(ram_we_hi), 32'(exp_we_hi));
        check({tag, " we_lo"}, 32'(ram_we_lo), 32'(exp_we_lo));
        if (wr) begin
            check({tag, " wd_hi"}, 32'(ram_wdata_hi), 32'(wide ? wdata[15:8] : wdata[7:0]));
            check({tag, " wd_lo"}, 32'(ram_wdata_lo), 32'(wdata[7:0]));
        end
        @(posedge clk); #1;
        check({tag, " we off"}, 32'({ram_we_hi, ram_we_lo}), 32'd0);
        check({tag, " early ack"}, 32'(cpu_ack), 32'd0);
        @(posedge clk); #1;
        check({tag, " ack"}, 32'(cpu_ack), 32'd1);
        if (!wr) check({tag, " rdata"}, 32'(cpu_rdata), 32'(exp_rdata));
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check({tag, " ack drop"}, 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        logic [7:0] got [8];
        string      exp_order;
        int         n_got;
        int         whi0;
        int         wlo0;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wide = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        vid_req = 1'b0; vid_addr = 16'h0;

        // Reset state, then idle with no requests.
        repeat (2) @(negedge clk);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst we", 32'({ram_we_hi, ram_we_lo}), 32'd0);
        check("rst wdata", 32'({ram_wdata_hi, ram_wdata_lo}), 32'd0);
        check("rst acks", 32'({cpu_ack, vid_ack}), 32'd0);
        check("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst vid_rdata", 32'(vid_rdata), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle no we", 32'(cnt_we_hi + cnt_we_lo), 32'd0);
        check("idle no ack", 32'({cpu_ack, vid_ack}), 32'd0);

        // Wide and byte lanes, big-endian.
        cpu_op("wwide", 1'b1, 1'b1, 16'hF600, 16'h1234, 1'b1, 1'b1, 16'h0000);
        cpu_op("rwide", 1'b0, 1'b1, 16'hF600, 16'h0000, 1'b0, 1'b0, 16'h1234);
        cpu_op("wb_odd", 1'b1, 1'b0, 16'hF601, 16'h0041, 1'b0, 1'b1, 16'h0000);
        cpu_op("wb_even", 1'b1, 1'b0, 16'hF600, 16'h0042, 1'b1, 1'b0, 16'h0000);
        cpu_op("rb_even", 1'b0, 1'b0, 16'hF600, 16'h0000, 1'b0, 1'b0, 16'h0042);
        cpu_op("rb_odd", 1'b0, 1'b0, 16'hF601, 16'h0000, 1'b0, 1'b0, 16'h0041);
        cpu_op("rwide2", 1'b0, 1'b1, 16'hF600, 16'h0000, 1'b0, 1'b0, 16'h4241);
        cpu_op("wpre", 1'b1, 1'b1, 16'hF602, 16'hABCD, 1'b1, 1'b1, 16'h0000);

        // Video read at an odd byte address.
        whi0 = cnt_we_hi; wlo0 = cnt_we_lo;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'hF603;
        @(posedge clk); #1;
        check("vid addr", 32'(ram_addr), 32'h7B01);
        check("vid we", 32'({ram_we_hi, ram_we_lo}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("vid ack", 32'(vid_ack), 32'd1);
        check("vid cpu_ack", 32'(cpu_ack), 32'd0);
        check("vid rdata", 32'(vid_rdata), 32'hABCD);
        check("vid cpu_rdata hold", 32'(cpu_rdata), 32'h4241);
        @(negedge clk);
        vid_req = 1'b0;
        @(posedge clk); #1;
        check("vid no writes", 32'((cnt_we_hi - whi0) + (cnt_we_lo - wlo0)), 32'd0);

        // Contention with both requests held high.
        exp_order = "VVVCVVVC";
        n_got = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_wide = 1'b1; cpu_addr = 16'hF600;
        vid_req = 1'b1; vid_addr = 16'hF602;
        for (int cyc = 0; cyc < 80 && n_got < 8; cyc++) begin
            @(posedge clk); #1;
            if (cpu_ack && vid_ack) begin
                got[n_got] = "X";
                n_got++;
            end else if (cpu_ack) begin
                got[n_got] = "C";
                n_got++;
            end else if (vid_ack) begin
                got[n_got] = "V";
                n_got++;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        check("cont grants", 32'(n_got), 32'd8);
        for (int i = 0; i < n_got; i++)
            check($sformatf("cont grant%0d", i), 32'(got[i]), 32'(exp_order[i]));
        repeat (2) @(posedge clk);

        // Reset during the ACCESS cycle of a CPU write.
        whi0 = cnt_we_hi; wlo0 = cnt_we_lo;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_wide = 1'b1; cpu_addr = 16'h1000; cpu_wdata = 16'h5AA5;
        @(posedge clk); #1;
        check("mid we before", 32'({ram_we_hi, ram_we_lo}), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("mid we dropped", 32'({ram_we_hi, ram_we_lo}), 32'd0);
        check("mid cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("mid vid_rdata", 32'(vid_rdata), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("mid no ack", 32'(cpu_ack), 32'd0);
        end
        check("mid no write", 32'((cnt_we_hi - whi0) + (cnt_we_lo - wlo0)), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("regrant addr", 32'(ram_addr), 32'h0800);
        check("regrant we", 32'({ram_we_hi, ram_we_lo}), 32'd3);
        @(posedge clk); #1;
        check("regrant early ack", 32'(cpu_ack), 32'd0);
        @(posedge clk); #1;
        check("regrant ack", 32'(cpu_ack), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("regrant once hi", 32'(cnt_we_hi - whi0), 32'd1);
        check("regrant once lo", 32'(cnt_we_lo - wlo0), 32'd1);
        check("regrant data", 32'({mem_hi[15'h0800], mem_lo[15'h0800]}), 32'h5AA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
